// File: rtl/ssd1306_digit_renderer.sv
// ssd1306_digit_renderer
// Snapshots NUM_DIGITS BCD digits when a frame is requested. It renders them with a 5x7 font
// scaled 2x into a PAGES x COLUMNS byte frame. It then sends one sync strobe and every frame byte
// (horizontal order, bit0 = top row) to the SSD1306 driver, one byte per strobe/ready handshake.
//
// Handshake: a strobe (drv_sync_stb_out / drv_write_stb_out) is only asserted in a cycle where
// drv_ready_in is high, and that cycle counts as the transfer. Afterwards the driver's ready is
// ignored for one cycle (blanking), then the block waits for ready to come back before moving on.
//
// Optional build macro RENDERER_LEADING_ZERO_BLANK_EN: leading zero digits render blank, but the
// rightmost digit is never blanked.
module ssd1306_digit_renderer #(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_WIDTH = 16,
    parameter int COLUMNS     = 128,
    parameter int PAGES       = 4,
    parameter int DIGIT_PAGE  = 1
) (
    input  logic                    clk_in,
    input  logic                    rstn_in,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    frame_stb_in,
    input  logic                    drv_ready_in,
    output logic                    drv_sync_stb_out,
    output logic                    drv_write_stb_out,
    output logic [7:0]              drv_data_out,
    output logic                    busy_out,
    output logic                    frame_done_out,
    output logic [2:0]              state_out
);

    localparam int TOTAL = PAGES * COLUMNS;
    localparam int CNT_W = $clog2(TOTAL);
    localparam int OFF   = (DIGIT_WIDTH - 10) / 2;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(TOTAL - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SYNC      = 3'd1;
    localparam logic [2:0] SYNC_WAIT = 3'd2;
    localparam logic [2:0] FETCH     = 3'd3;
    localparam logic [2:0] SEND      = 3'd4;
    localparam logic [2:0] SEND_WAIT = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]              state;
    logic                    pending;
    logic                    blank;
    logic [4*NUM_DIGITS-1:0] snapshot;
    logic [CNT_W-1:0]        byte_cnt;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [7:0]              render_byte;

    int         r_idx;
    int         r_page;
    int         r_col;
    int         r_dig;
    int         r_c;
    logic [3:0] r_code;
    logic [6:0] r_glyph;
    logic [15:0] r_scaled;

    // Glyph column fc (0..4) of digit code; fields are packed left column first.
    function automatic logic [6:0] font_col(input logic [3:0] code, input logic [2:0] fc);
        logic [34:0] glyph;
        case (code)
            4'd0:    glyph = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            4'd1:    glyph = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
            4'd2:    glyph = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
            4'd3:    glyph = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
            4'd4:    glyph = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
            4'd5:    glyph = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
            4'd6:    glyph = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
            4'd7:    glyph = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
            4'd8:    glyph = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            4'd9:    glyph = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
            default: glyph = '0;
        endcase
        case (fc)
            3'd0:    font_col = glyph[34:28];
            3'd1:    font_col = glyph[27:21];
            3'd2:    font_col = glyph[20:14];
            3'd3:    font_col = glyph[13:7];
            3'd4:    font_col = glyph[6:0];
            default: font_col = '0;
        endcase
    endfunction

`ifdef RENDERER_LEADING_ZERO_BLANK_EN
    // Blank every digit left of the first non-zero one, but always keep the rightmost digit.
    always_comb begin
        logic seen_nz;
        seen_nz  = 1'b0;
        lz_blank = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (snapshot[4*(NUM_DIGITS-1-k) +: 4] != 4'd0) seen_nz = 1'b1;
            lz_blank[k] = !seen_nz && (k != NUM_DIGITS - 1);
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Render the frame byte addressed by byte_cnt from the digit snapshot.
    always_comb begin
        r_idx    = int'(byte_cnt);
        r_page   = r_idx / COLUMNS;
        r_col    = r_idx % COLUMNS;
        r_dig    = r_col / DIGIT_WIDTH;
        r_c      = r_col % DIGIT_WIDTH;
        r_code   = snapshot[4*(NUM_DIGITS-1-r_dig) +: 4];
        r_glyph  = '0;
        r_scaled = '0;
        if (r_c >= OFF && r_c < OFF + 10 && r_code <= 4'd9 && !lz_blank[r_dig]) begin
            r_glyph = font_col(r_code, 3'((r_c - OFF) >> 1));
        end
        for (int i = 0; i < 7; i++) begin
            r_scaled[2*i]   = r_glyph[i];
            r_scaled[2*i+1] = r_glyph[i];
        end
        if (r_page == DIGIT_PAGE) begin
            render_byte = r_scaled[7:0];
        end else if (r_page == DIGIT_PAGE + 1) begin
            render_byte = r_scaled[15:8];
        end else begin
            render_byte = 8'h00;
        end
    end

    // Frame sequencer: snapshot, sync, then fetch/send each byte in order.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state        <= IDLE;
            blank        <= 1'b0;
            snapshot     <= '0;
            byte_cnt     <= '0;
            drv_data_out <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_stb_in || pending) begin
                        snapshot <= digits_in;
                        byte_cnt <= '0;
                        state    <= SYNC;
                    end
                end
                SYNC: begin
                    if (drv_ready_in) begin
                        blank <= 1'b1;
                        state <= SYNC_WAIT;
                    end
                end
                SYNC_WAIT: begin
                    if (blank) begin
                        blank <= 1'b0;
                    end else if (drv_ready_in) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    drv_data_out <= render_byte;
                    state        <= SEND;
                end
                SEND: begin
                    if (drv_ready_in) begin
                        blank <= 1'b1;
                        state <= SEND_WAIT;
                    end
                end
                SEND_WAIT: begin
                    if (blank) begin
                        blank <= 1'b0;
                    end else if (drv_ready_in) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state <= DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One-deep request memory: a request arriving outside IDLE (DONE included) is kept for later.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            pending <= 1'b0;
        end else if (state == IDLE && (frame_stb_in || pending)) begin
            pending <= 1'b0;
        end else if (frame_stb_in) begin
            pending <= 1'b1;
        end
    end

    // Strobes are gated by ready in the same cycle, so they can never fire while ready is low.
    always_comb begin
        drv_sync_stb_out  = (state == SYNC) && drv_ready_in;
        drv_write_stb_out = (state == SEND) && drv_ready_in;
        busy_out          = (state != IDLE) && (state != DONE);
        frame_done_out    = (state == DONE);
        state_out         = state;
    end

endmodule

// File: tb/tb_ssd1306_digit_renderer.sv
// Bench for ssd1306_digit_renderer: driver model with 3-cycle ready drop, frame scoreboard fed
// from a spec-level rendering model, plus literal byte checks.
module tb_ssd1306_digit_renderer;
  localparam int TOTAL = 512;

  logic        clk_in = 1'b0;
  logic        rstn_in;
  logic [31:0] digits_in;
  logic        frame_stb_in;
  logic        drv_ready_in;
  logic        drv_sync_stb_out;
  logic        drv_write_stb_out;
  logic [7:0]  drv_data_out;
  logic        busy_out;
  logic        frame_done_out;
  logic [2:0]  state_out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] frame_q[$];
  logic [7:0]  frame_bytes [0:TOTAL-1];
  int syncs = 0, writes = 0, dones = 0, wr_in_frame = 0;
  logic hold_ready = 1'b0;

  logic [6:0] font [0:49] = '{
    7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E,
    7'h00, 7'h42, 7'h7F, 7'h40, 7'h00,
    7'h42, 7'h61, 7'h51, 7'h49, 7'h46,
    7'h21, 7'h41, 7'h45, 7'h4B, 7'h31,
    7'h18, 7'h14, 7'h12, 7'h7F, 7'h10,
    7'h27, 7'h45, 7'h45, 7'h45, 7'h39,
    7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30,
    7'h01, 7'h71, 7'h09, 7'h05, 7'h03,
    7'h36, 7'h49, 7'h49, 7'h49, 7'h36,
    7'h06, 7'h49, 7'h49, 7'h29, 7'h1E
  };

  ssd1306_digit_renderer dut (
    .clk_in            (clk_in),
    .rstn_in           (rstn_in),
    .digits_in         (digits_in),
    .frame_stb_in      (frame_stb_in),
    .drv_ready_in      (drv_ready_in),
    .drv_sync_stb_out  (drv_sync_stb_out),
    .drv_write_stb_out (drv_write_stb_out),
    .drv_data_out      (drv_data_out),
    .busy_out          (busy_out),
    .frame_done_out    (frame_done_out),
    .state_out         (state_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // Expected frame byte: band rows 0..15 of pages 1..2 show the glyph column doubled vertically.
  function automatic logic [7:0] model_byte(input logic [31:0] digs, input int idx);
    int page, col, d, c, row;
    logic [3:0] code;
    logic [6:0] g;
    logic [7:0] b;
    bit blank;
    page = idx / 128;
    col  = idx % 128;
    d    = col / 16;
    c    = col % 16;
    g    = '0;
    b    = '0;
    blank = 1'b0;
`ifdef RENDERER_LEADING_ZERO_BLANK_EN
    blank = (d != 7);
    for (int k = 0; k <= d; k++) begin
      if (digs[31-4*k -: 4] != 4'd0) blank = 1'b0;
    end
`endif
    code = digs[31-4*d -: 4];
    if (code <= 4'd9 && !blank && c >= 3 && c < 13) g = font[int'(code) * 5 + (c - 3) / 2];
    if (page == 1 || page == 2) begin
      for (int r = 0; r < 8; r++) begin
        row = (page - 1) * 8 + r;
        if (row / 2 < 7) b[r] = g[row / 2];
      end
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver model: ready drops for 3 cycles after every strobe; hold_ready forces it low
  initial begin
    int cooldown;
    cooldown = 0;
    drv_ready_in = 1'b1;
    forever begin
      @(negedge clk_in);
      if (rstn_in && (drv_sync_stb_out || drv_write_stb_out)) cooldown = 3;
      @(posedge clk_in);
      #1;
      if (cooldown > 0) begin
        cooldown--;
        drv_ready_in = 1'b0;
      end else begin
        drv_ready_in = !hold_ready;
      end
    end
  end

  // compare process: protocol rules plus scoreboard on every strobe / done
  initial begin
    logic prev_stb;
    logic [31:0] d;
    logic [7:0] e;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rstn_in) begin
        prev_stb = 1'b0;
      end else begin
        if (drv_sync_stb_out || drv_write_stb_out) begin
          check("stb_while_ready_low", drv_ready_in, 1'b1);
          check("stb_back_to_back", prev_stb, 1'b0);
        end
        if (drv_sync_stb_out) begin
          syncs++;
          check("sync_leftover_bytes", exp_q.size(), 0);
          check("sync_frame_expected", frame_q.size() != 0, 1'b1);
          if (frame_q.size() != 0) begin
            d = frame_q.pop_front();
            exp_q.delete();
            for (int i = 0; i < TOTAL; i++) exp_q.push_back(model_byte(d, i));
          end
          wr_in_frame = 0;
        end
        if (drv_write_stb_out) begin
          writes++;
          if (exp_q.size() == 0) begin
            check("write_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("frame_byte[%0d]", wr_in_frame), drv_data_out, e);
          end
          if (wr_in_frame < TOTAL) frame_bytes[wr_in_frame] = drv_data_out;
          wr_in_frame++;
        end
        if (frame_done_out) begin
          dones++;
          check("done_byte_count", wr_in_frame, TOTAL);
          check("done_busy_low", busy_out, 1'b0);
        end
        prev_stb = drv_sync_stb_out || drv_write_stb_out;
      end
    end
  end

  // driver tasks
  task automatic pulse_frame(input logic [31:0] digs);
    @(posedge clk_in);
    #1;
    digits_in = digs;
    frame_stb_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_stb_in = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n;
    n = 0;
    while (dones < target && n < budget) begin
      @(posedge clk_in);
      n++;
    end
    check("frame_done_timeout", dones >= target, 1'b1);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n;
    n = 0;
    while (wr_in_frame < target && n < budget) begin
      @(posedge clk_in);
      n++;
    end
    check("byte_wait_timeout", wr_in_frame >= target, 1'b1);
  endtask

  initial begin
    int s0, w0, d0, wb, busy_bad, n;
    logic nz;
    rstn_in = 1'b0;
    digits_in = '0;
    frame_stb_in = 1'b0;

    // 1: reset state and idle with ready high
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_sync_stb", drv_sync_stb_out, 0);
    check("rst_write_stb", drv_write_stb_out, 0);
    check("rst_data", drv_data_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", frame_done_out, 0);
    @(posedge clk_in);
    #1;
    rstn_in = 1'b1;
    repeat (20) @(posedge clk_in);
    check("idle_no_sync", syncs, 0);
    check("idle_no_write", writes, 0);

    // 2: one all-zero frame
    s0 = syncs; w0 = writes; d0 = dones;
    frame_q.push_back(32'h0000_0000);
    pulse_frame(32'h0000_0000);
    wait_dones(d0 + 1, 8000);
    repeat (5) @(posedge clk_in);
    check("f1_syncs", syncs - s0, 1);
    check("f1_writes", writes - w0, 512);
    check("f1_dones", dones - d0, 1);
`ifdef RENDERER_LEADING_ZERO_BLANK_EN
    check("lit_byte131_blank", frame_bytes[131], 8'h00);
    check("lit_byte243_zero", frame_bytes[243], 8'hFC);
`else
    check("lit_byte131", frame_bytes[131], 8'hFC);
    check("lit_byte259", frame_bytes[259], 8'h0F);
`endif
    check("lit_byte383", frame_bytes[383], 8'h00);
    nz = 1'b0;
    for (int i = 0; i < 128; i++) if (frame_bytes[i] != 8'h00) nz = 1'b1;
    check("lit_page0_zero", nz, 1'b0);

    // 3: ready held low mid-frame
    d0 = dones;
    frame_q.push_back(32'h1234_5678);
    pulse_frame(32'h1234_5678);
    wait_bytes(100, 2000);
    @(posedge clk_in);
    #1;
    hold_ready = 1'b1;
    drv_ready_in = 1'b0;
    wb = writes;
    n = wr_in_frame;
    busy_bad = 0;
    repeat (50) begin
      @(negedge clk_in);
      if (!busy_out) busy_bad++;
    end
    check("hold_no_writes", writes, wb);
    check("hold_same_byte", wr_in_frame, n);
    check("hold_busy", busy_bad, 0);
    hold_ready = 1'b0;
    wait_dones(d0 + 1, 8000);

    // 4: two requests while busy with digits changed between them
    s0 = syncs; w0 = writes; d0 = dones;
    frame_q.push_back(32'h9876_5432);
    frame_q.push_back(32'h1029_3847);
    pulse_frame(32'h9876_5432);
    repeat (10) @(posedge clk_in);
    pulse_frame(32'h1111_1111);
    repeat (10) @(posedge clk_in);
    pulse_frame(32'h1029_3847);
    wait_dones(d0 + 2, 16000);
    repeat (200) @(posedge clk_in);
    check("two_req_syncs", syncs - s0, 2);
    check("two_req_dones", dones - d0, 2);
    check("two_req_writes", writes - w0, 1024);

    // request landing exactly in the DONE cycle is kept
    s0 = syncs; d0 = dones;
    frame_q.push_back(32'h0000_0042);
    frame_q.push_back(32'h0000_0042);
    pulse_frame(32'h0000_0042);
    n = 0;
    while (!frame_done_out && n < 8000) begin
      @(negedge clk_in);
      n++;
    end
    check("done_seen", frame_done_out, 1'b1);
    frame_stb_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_stb_in = 1'b0;
    wait_dones(d0 + 2, 16000);
    repeat (20) @(posedge clk_in);
    check("done_req_syncs", syncs - s0, 2);
    check("lit_42_col99", frame_bytes[227], 8'hC0);
    check("lit_42_col115", frame_bytes[243], 8'h0C);
`ifdef RENDERER_LEADING_ZERO_BLANK_EN
    nz = 1'b0;
    for (int i = 128; i < 224; i++) if (frame_bytes[i] != 8'h00) nz = 1'b1;
    for (int i = 256; i < 352; i++) if (frame_bytes[i] != 8'h00) nz = 1'b1;
    check("lzb_cols_0_95_blank", nz, 1'b0);
`else
    check("lit_42_leading0", frame_bytes[131], 8'hFC);
`endif

    // 6: reset mid-frame, then a clean restart
    frame_q.push_back(32'h8765_4321);
    pulse_frame(32'h8765_4321);
    wait_bytes(200, 3000);
    @(posedge clk_in);
    #2;
    rstn_in = 1'b0;
    #1;
    check("abort_busy", busy_out, 0);
    check("abort_sync_stb", drv_sync_stb_out, 0);
    check("abort_write_stb", drv_write_stb_out, 0);
    check("abort_data", drv_data_out, 0);
    check("abort_done", frame_done_out, 0);
    exp_q.delete();
    frame_q.delete();
    repeat (3) @(posedge clk_in);
    #1;
    rstn_in = 1'b1;
    s0 = syncs; w0 = writes; d0 = dones;
    frame_q.push_back(32'h8765_4321);
    pulse_frame(32'h8765_4321);
    wait_dones(d0 + 1, 8000);
    repeat (5) @(posedge clk_in);
    check("restart_syncs", syncs - s0, 1);
    check("restart_writes", writes - w0, 512);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
